// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: datapath width, access FSM states, MEM/WB bundle.
package mem_access_stage_pkg;
  localparam int XLEN = 64;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [XLEN-1:0] readdata;
    logic [XLEN-1:0] aluresult;
    logic [4:0]      rd;
    logic            memtoreg;
    logic            regwrite;
    logic            valid;
  } memwb_t;

  localparam int MEMWB_W = $bits(memwb_t);
endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register; reset and bubble-load both clear every field.
module memwb_reg import mem_access_stage_pkg::*; #(
  parameter int W = MEMWB_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_bubble,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_bubble) r_q <= '0;
    else                      r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory handshake with stall/timeout, branch redirect, MEM/WB register.
// Optional macro MEM_ALIGN_CHECK_EN rejects accesses whose address is not 8-byte aligned.
module mem_access_stage #(
  parameter int XLEN        = mem_access_stage_pkg::XLEN,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] Adderout,
  input  logic [XLEN-1:0] result_out_alu,
  input  logic [XLEN-1:0] writedata_out,
  input  logic            zero,
  input  logic            Branch,
  input  logic            Memread,
  input  logic            Memtoreg,
  input  logic            Memwrite,
  input  logic            Regwrite,
  input  logic            addermuxselect,
  input  logic [4:0]      rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            pc_src,
  output logic            flush,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] wb_readdata,
  output logic [XLEN-1:0] wb_aluresult,
  output logic [4:0]      wb_rd,
  output logic            wb_Memtoreg,
  output logic            wb_Regwrite,
  output logic            wb_valid,
  output logic            mem_err
);
  import mem_access_stage_pkg::*;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_mem_err;
  logic       w_access, w_misalign, w_go, w_abort, w_stall, w_bubble;
  memwb_t     w_memwb_d, w_memwb_q;

  assign w_access = Memread | Memwrite;
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access & (result_out_alu[2:0] != 3'b000);
`else
  assign w_misalign = 1'b0;
`endif
  // w_go: an access that is actually presented to data memory
  assign w_go    = w_access & ~w_misalign;
  assign w_abort = (r_state == WAIT) & (r_cnt == TMO_LAST) & ~dmem_ack;
  assign w_stall = w_go & ~dmem_ack & ~w_abort;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go & ~dmem_ack) w_state_nxt = WAIT;
      WAIT:    if (dmem_ack | w_abort | ~w_go) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    pc_src   = 1'b0;
    flush    = 1'b0;
    if (reset) begin
      dmem_req = w_go;
      stall    = w_stall;
      pc_src   = Branch & zero & ~w_stall;
      flush    = Branch & zero & ~w_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || r_state == IDLE) r_cnt <= '0;
    else                           r_cnt <= r_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_mem_err <= 1'b0;
    else        r_mem_err <= w_abort | w_misalign;
  end

  assign w_bubble = w_stall | w_abort | w_misalign;

  always_comb begin
    w_memwb_d = '0;
    w_memwb_d.readdata[XLEN-1:0]  = (w_go & Memread & ~Memwrite) ? dmem_rdata : '0;
    w_memwb_d.aluresult[XLEN-1:0] = result_out_alu;
    w_memwb_d.rd                  = rd;
    w_memwb_d.memtoreg            = Memtoreg;
    w_memwb_d.regwrite            = Regwrite;
    w_memwb_d.valid               = 1'b1;
  end

  memwb_reg #(.W(MEMWB_W)) u_memwb (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_bubble(w_bubble),
    .i_d     (w_memwb_d),
    .o_q     (w_memwb_q)
  );

  assign dmem_addr     = result_out_alu;
  assign dmem_wdata    = writedata_out;
  assign dmem_we       = Memwrite;
  assign branch_target = addermuxselect ? result_out_alu : Adderout;
  assign wb_readdata   = w_memwb_q.readdata[XLEN-1:0];
  assign wb_aluresult  = w_memwb_q.aluresult[XLEN-1:0];
  assign wb_rd         = w_memwb_q.rd;
  assign wb_Memtoreg   = w_memwb_q.memtoreg;
  assign wb_Regwrite   = w_memwb_q.regwrite;
  assign wb_valid      = w_memwb_q.valid;
  assign mem_err       = r_mem_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a per-operation behavioural model.
module tb_mem_access_stage;
  localparam int TMO = 255;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Adderout, result_out_alu, writedata_out, dmem_rdata;
  logic        zero, Branch, Memread, Memtoreg, Memwrite, Regwrite, addermuxselect, dmem_ack;
  logic [4:0]  rd, wb_rd;
  logic        dmem_req, dmem_we, stall, pc_src, flush;
  logic [63:0] dmem_addr, dmem_wdata, branch_target, wb_readdata, wb_aluresult;
  logic        wb_Memtoreg, wb_Regwrite, wb_valid, mem_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(64), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .Adderout(Adderout), .result_out_alu(result_out_alu), .writedata_out(writedata_out),
    .zero(zero), .Branch(Branch), .Memread(Memread), .Memtoreg(Memtoreg),
    .Memwrite(Memwrite), .Regwrite(Regwrite), .addermuxselect(addermuxselect), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_src(pc_src), .flush(flush), .branch_target(branch_target),
    .wb_readdata(wb_readdata), .wb_aluresult(wb_aluresult), .wb_rd(wb_rd),
    .wb_Memtoreg(wb_Memtoreg), .wb_Regwrite(wb_Regwrite), .wb_valid(wb_valid),
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".wb_valid"}, wb_valid, 1'b0);
    chk({tag, ".wb_Regwrite"}, wb_Regwrite, 1'b0);
    chk({tag, ".wb_Memtoreg"}, wb_Memtoreg, 1'b0);
    chk({tag, ".wb_rd"}, wb_rd, 5'd0);
  endtask

  // One EX/MEM instruction held until the stage releases it; called at posedge+1.
  task automatic run_op(input logic mr, input logic mw, input logic br, input logic z,
                        input logic ams, input logic mtr, input logic rw,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] add, input logic [63:0] rdv,
                        input logic [4:0] rdn, input int lat, input bit ack_always);
    bit acc, mis, abrt, exp_stall;
    int last;
    Memread = mr; Memwrite = mw; Branch = br; zero = z; addermuxselect = ams;
    Memtoreg = mtr; Regwrite = rw; result_out_alu = addr; writedata_out = wd;
    Adderout = add; rd = rdn;
    acc  = mr | mw;
    mis  = ALIGN && acc && (addr[2:0] != 3'd0);
    abrt = acc && !mis && (lat > TMO);
    last = (!acc || mis) ? 0 : ((lat < TMO) ? lat : TMO);
    for (int c = 0; c <= last; c++) begin
      dmem_ack   = ack_always || (acc && c == lat);
      dmem_rdata = (c == lat) ? rdv : {$urandom, $urandom};
      @(negedge clk);
      exp_stall = acc && !mis && (c < last);
      chk("stall", stall, exp_stall);
      chk("dmem_req", dmem_req, acc && !mis);
      chk("dmem_we", dmem_we, mw);
      chk("dmem_addr", dmem_addr, addr);
      chk("dmem_wdata", dmem_wdata, wd);
      chk("pc_src", pc_src, br && z && !exp_stall);
      chk("flush", flush, br && z && !exp_stall);
      chk("branch_target", branch_target, ams ? addr : add);
      @(posedge clk); #1;
      if (c < last) begin
        chk_bubble("stall_bubble");
        chk("mem_err_quiet", mem_err, 1'b0);
      end
    end
    dmem_ack = 1'b0;
    if (abrt || mis) begin
      chk_bubble("abort_bubble");
      chk("mem_err_pulse", mem_err, 1'b1);
    end else begin
      chk("wb_valid", wb_valid, 1'b1);
      chk("wb_readdata", wb_readdata, (mr && !mw) ? rdv : 64'd0);
      chk("wb_aluresult", wb_aluresult, addr);
      chk("wb_rd", wb_rd, rdn);
      chk("wb_Memtoreg", wb_Memtoreg, mtr);
      chk("wb_Regwrite", wb_Regwrite, rw);
      chk("mem_err", mem_err, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    Adderout = '0; result_out_alu = '0; writedata_out = '0;
    zero = 1'b1; Branch = 1'b1; Memread = 1'b1; Memwrite = 1'b0;
    Memtoreg = 1'b0; Regwrite = 1'b0; addermuxselect = 1'b0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_bubble("reset");
    chk("reset.wb_readdata", wb_readdata, 64'd0);
    chk("reset.mem_err", mem_err, 1'b0);
    @(negedge clk);
    chk("reset.dmem_req", dmem_req, 1'b0);
    chk("reset.stall", stall, 1'b0);
    chk("reset.pc_src", pc_src, 1'b0);
    chk("reset.flush", flush, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // load, zero-wait ack
    run_op(1, 0, 0, 0, 0, 1, 1, 64'h100, 64'h0, 64'h0, 64'hDEADBEEF, 5'd7, 0, 0);
    // store, ack after three cycles
    run_op(0, 1, 0, 0, 0, 0, 0, 64'h208, 64'h55, 64'h0, 64'h0, 5'd3, 3, 0);
    // taken and not-taken branch
    run_op(0, 0, 1, 1, 0, 0, 0, 64'h0, 64'h0, 64'h400, 64'h0, 5'd0, 0, 0);
    run_op(0, 0, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h400, 64'h0, 5'd0, 0, 0);
    // read+write together behaves as a write
    run_op(1, 1, 0, 0, 0, 0, 0, 64'h300, 64'h77, 64'h0, 64'h1234, 5'd9, 1, 0);
    // ack never arrives, then a stray ack while a non-access passes through
    run_op(1, 0, 0, 0, 0, 1, 1, 64'h180, 64'h0, 64'h0, 64'h0, 5'd5, 1000, 0);
    run_op(0, 0, 0, 0, 1, 0, 1, 64'h40, 64'h0, 64'h0, 64'hFFFF, 5'd6, 0, 1);
    // ack arrives exactly on the last allowed cycle
    run_op(1, 0, 0, 0, 0, 1, 1, 64'h1F8, 64'h0, 64'h0, 64'hA5A5, 5'd11, TMO, 0);
`ifdef MEM_ALIGN_CHECK_EN
    run_op(1, 0, 0, 0, 0, 1, 1, 64'h103, 64'h0, 64'h0, 64'h99, 5'd4, 0, 0);
`endif

    // reset asserted mid-WAIT
    Memread = 1'b1; Memwrite = 1'b0; Regwrite = 1'b1; Memtoreg = 1'b1; rd = 5'd12;
    result_out_alu = 64'h500; Branch = 1'b1; zero = 1'b1; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midwait_reset.dmem_req", dmem_req, 1'b0);
    chk("midwait_reset.stall", stall, 1'b0);
    chk("midwait_reset.pc_src", pc_src, 1'b0);
    @(posedge clk); #1;
    chk_bubble("midwait_reset");
    chk("midwait_reset.wb_readdata", wb_readdata, 64'd0);
    chk("midwait_reset.wb_aluresult", wb_aluresult, 64'd0);
    chk("midwait_reset.mem_err", mem_err, 1'b0);
    Memread = 1'b0; Branch = 1'b0;
    reset = 1'b1;
    run_op(1, 0, 0, 0, 0, 1, 1, 64'h600, 64'h0, 64'h0, 64'hC0FFEE, 5'd13, 2, 0);

    for (int i = 0; i < 80; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 5'($urandom), int'($urandom_range(0, 4)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter XLEN, default 64: datapath width.
REQ-002 Parameter ACK_TIMEOUT, default 255: max cycles awaiting dmem_ack before abort.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-low; 0 = reset.
REQ-005 Adderout, result_out_alu, writedata_out  input  XLEN each: branch-adder target, ALU result/address, store data from EX/MEM.
REQ-006 zero, Branch, Memread, Memtoreg, Memwrite, Regwrite, addermuxselect  input  1 each; rd  input  5: EX/MEM control.
REQ-007 dmem_req, dmem_we  output  1; dmem_addr, dmem_wdata  output  XLEN: data-memory request.
REQ-008 dmem_ack  input  1; dmem_rdata  input  XLEN: data-memory response.
REQ-009 stall  output  1: holds PC, IF/ID, ID/EX, EX/MEM.
REQ-010 pc_src, flush  output  1; branch_target  output  XLEN: redirect to fetch.
REQ-011 wb_readdata, wb_aluresult  output  XLEN; wb_rd  output  5; wb_Memtoreg, wb_Regwrite, wb_valid  output  1: MEM/WB register.
REQ-012 mem_err  output  1: one-cycle pulse on timeout or misalignment.

Function
REQ-013 access = Memread | Memwrite; Memread and Memwrite both 1 is treated as a write.
REQ-014 FSM states IDLE, WAIT; IDLE -> WAIT when access & !dmem_ack; WAIT -> IDLE on dmem_ack or on timeout.
REQ-015 dmem_req = access in IDLE or WAIT (combinational); dmem_addr = result_out_alu, dmem_wdata = writedata_out, dmem_we = Memwrite; all held stable while dmem_req is 1 and dmem_ack is 0.
REQ-016 stall = access & !dmem_ack & !abort, where abort is the timeout condition.
REQ-017 On dmem_ack, MEM/WB captures dmem_rdata (reads only, else 0), result_out_alu, rd, Memtoreg, Regwrite, and wb_valid=1; zero-wait ack gives 1-cycle latency with no stall.
REQ-018 Non-access instructions pass to MEM/WB in one cycle with wb_readdata=0.
REQ-019 While stall=1, MEM/WB loads a bubble: wb_Regwrite=0, wb_Memtoreg=0, wb_valid=0, wb_rd=0.
REQ-020 pc_src = Branch & zero; branch_target = addermuxselect ? result_out_alu : Adderout; flush = pc_src; both combinational; stall has priority and forces pc_src=flush=0.
REQ-021 Wait counter: 8-bit, cleared in IDLE, increments each WAIT cycle; at ACK_TIMEOUT the access aborts, MEM/WB loads a bubble, mem_err pulses, state -> IDLE, stall drops.
REQ-022 A late dmem_ack arriving after an abort is ignored.

Reset
REQ-023 reset=0 at a clock edge: state=IDLE, counter=0, all MEM/WB outputs 0, mem_err=0, regardless of state including mid-WAIT.
REQ-024 While reset=0, dmem_req, stall, pc_src and flush are forced to 0.

Configuration
REQ-025 With MEM_ALIGN_CHECK_EN defined: access with result_out_alu[2:0] != 0 issues no dmem_req, loads a bubble, pulses mem_err, no stall.
REQ-026 Without MEM_ALIGN_CHECK_EN: no alignment check; the address is passed through unmodified.

Structure
REQ-027 Shared package holds XLEN, the FSM state enum {IDLE, WAIT} and the MEM/WB bundle typedef.
REQ-028 One sub-module, memwb_reg: the MEM/WB pipeline register with bubble-load and reset.

Verification
REQ-029 Load, addr 0x100, ack same cycle, rdata 0xDEADBEEF -> stall never 1; next cycle wb_readdata=0xDEADBEEF, wb_valid=1.
REQ-030 Store, addr 0x208, data 0x55, ack after 3 cycles -> stall=1 for 3 cycles, dmem_addr/dmem_wdata stable, 3 bubbles, then wb_valid=1, wb_Regwrite=0.
REQ-031 Branch=1, zero=1, addermuxselect=0, Adderout=0x400 -> pc_src=flush=1, branch_target=0x400 same cycle; zero=0 -> pc_src=0.
REQ-032 Load, ack never arrives -> stall for 255 cycles, mem_err pulse, bubble, stall=0; a later ack is ignored.
REQ-033 reset=0 during WAIT -> next edge: state IDLE, dmem_req=0, all wb_* = 0.
REQ-034 With MEM_ALIGN_CHECK_EN, load at 0x103 -> dmem_req=0, mem_err=1 for one cycle, wb_valid=0.
